// File: rtl/uartlite_pkg.sv
// Shared constants and FSM state types for the UART Lite AXI responder.
// Address decode uses bits [3:2] of the constants below.
package uartlite_pkg;

    localparam logic [3:0] ADDR_RX   = 4'h0;
    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hC;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;

    localparam int CTRL_CLR_TX = 0;
    localparam int CTRL_CLR_RX = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_ADDR,
        W_DATA,
        W_IDLE
    } wr_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with an extra pointer MSB to tell full from empty.
// Clear wins over a same-cycle push or pop; head reads 0 while empty.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       clear,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uartlite_axi_responder.sv
// AXI4-Lite slave that mimics the UART Lite register map, bridging register
// accesses to host-side RX/TX byte streams through two byte FIFOs.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_RESP | rvalid high with latched rdata, waiting for rready
// W_ADDR | awready high, waiting for a write address; bvalid may be pending
// W_DATA | wready high, waiting for write data to commit
// W_IDLE | not entered in normal operation; recovers to W_ADDR
module uartlite_axi_responder
    import uartlite_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        uart_araddr,
    input  logic              uart_arvalid,
    output logic              uart_arready,
    output logic [DATA_W-1:0] uart_rdata,
    output logic [1:0]        uart_rresp,
    output logic              uart_rvalid,
    input  logic              uart_rready,
    input  logic [3:0]        uart_awaddr,
    input  logic              uart_awvalid,
    output logic              uart_awready,
    input  logic [DATA_W-1:0] uart_wdata,
    input  logic [3:0]        uart_wstrb,
    input  logic              uart_wvalid,
    output logic              uart_wready,
    output logic [1:0]        uart_bresp,
    output logic              uart_bvalid,
    input  logic              uart_bready,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready
);

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic [1:0]        wr_sel;
    logic [1:0]        rd_sel;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              wr_commit;
    logic              ctrl_wr;
    logic              rx_pop;
    logic              tx_push;
    logic              clr_tx;
    logic              clr_rx;
    logic              rx_full;
    logic              rx_empty;
    logic [7:0]        rx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_bits;

    assign ar_hs     = uart_arvalid && uart_arready;
    assign aw_hs     = uart_awvalid && uart_awready;
    assign w_hs      = uart_wvalid && uart_wready;
    assign rd_sel    = uart_araddr[3:2];
    assign wr_commit = w_hs && uart_wstrb[0];
    assign tx_push   = wr_commit && (wr_sel == ADDR_TX[3:2]);
    assign ctrl_wr   = wr_commit && (wr_sel == ADDR_CTRL[3:2]);
    assign clr_tx    = ctrl_wr && uart_wdata[CTRL_CLR_TX];
    assign clr_rx    = ctrl_wr && uart_wdata[CTRL_CLR_RX];
    assign rx_pop    = ar_hs && (rd_sel == ADDR_RX[3:2]) && !rx_empty;

    assign rx_ready   = !rx_full;
    assign tx_valid   = !tx_empty;
    assign uart_rresp = RESP_OKAY;
    assign uart_bresp = RESP_OKAY;

    assign unused_bits = ^{uart_araddr[1:0], uart_awaddr[1:0],
                           uart_wdata[DATA_W-1:8], uart_wstrb[3:1]};

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_byte),
        .pop       (rx_pop),
        .clear     (clr_rx),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (uart_wdata[7:0]),
        .pop       (tx_ready),
        .clear     (clr_tx),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_byte)
    );

    // Read data is sampled in the address handshake cycle, before the pop lands.
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            ADDR_RX[3:2]: begin
                rd_mux[7:0] = rx_head;
            end
            ADDR_STAT[3:2]: begin
                rd_mux[STAT_RX_VALID] = !rx_empty;
                rd_mux[STAT_RX_FULL]  = rx_full;
                rd_mux[STAT_TX_EMPTY] = tx_empty;
                rd_mux[STAT_TX_FULL]  = tx_full;
            end
            default: begin
                rd_mux = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state     <= R_IDLE;
            uart_arready <= 1'b1;
            uart_rvalid  <= 1'b0;
            uart_rdata   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        uart_rdata   <= rd_mux;
                        uart_arready <= 1'b0;
                        uart_rvalid  <= 1'b1;
                        rd_state     <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (uart_rready) begin
                        uart_rvalid  <= 1'b0;
                        uart_arready <= 1'b1;
                        rd_state     <= R_IDLE;
                    end
                end
                default: begin
                    uart_rvalid  <= 1'b0;
                    uart_arready <= 1'b1;
                    rd_state     <= R_IDLE;
                end
            endcase
        end
    end

    // A new AW handshake retires any unacknowledged response so a master that
    // never asserts bready cannot stall the write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state     <= W_ADDR;
            wr_sel       <= '0;
            uart_awready <= 1'b1;
            uart_wready  <= 1'b0;
            uart_bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                W_ADDR: begin
                    if (aw_hs) begin
                        wr_sel       <= uart_awaddr[3:2];
                        uart_bvalid  <= 1'b0;
                        uart_awready <= 1'b0;
                        uart_wready  <= 1'b1;
                        wr_state     <= W_DATA;
                    end else if (uart_bvalid && uart_bready) begin
                        uart_bvalid <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        uart_wready  <= 1'b0;
                        uart_awready <= 1'b1;
                        uart_bvalid  <= 1'b1;
                        wr_state     <= W_ADDR;
                    end
                end
                default: begin
                    uart_wready  <= 1'b0;
                    uart_awready <= 1'b1;
                    wr_state     <= W_ADDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartlite_axi_responder.sv
// Scoreboard bench for uartlite_axi_responder: expected read data and TX/RX
// byte streams are queued at stimulus time and compared when the DUT responds.
module tb_uartlite_axi_responder;

    localparam int FIFO_DEPTH = 16;
    localparam int DATA_W     = 32;
    localparam int BUDGET     = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        uart_araddr;
    logic              uart_arvalid;
    logic              uart_arready;
    logic [DATA_W-1:0] uart_rdata;
    logic [1:0]        uart_rresp;
    logic              uart_rvalid;
    logic              uart_rready;
    logic [3:0]        uart_awaddr;
    logic              uart_awvalid;
    logic              uart_awready;
    logic [DATA_W-1:0] uart_wdata;
    logic [3:0]        uart_wstrb;
    logic              uart_wvalid;
    logic              uart_wready;
    logic [1:0]        uart_bresp;
    logic              uart_bvalid;
    logic              uart_bready;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    uartlite_axi_responder #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_araddr  (uart_araddr),
        .uart_arvalid (uart_arvalid),
        .uart_arready (uart_arready),
        .uart_rdata   (uart_rdata),
        .uart_rresp   (uart_rresp),
        .uart_rvalid  (uart_rvalid),
        .uart_rready  (uart_rready),
        .uart_awaddr  (uart_awaddr),
        .uart_awvalid (uart_awvalid),
        .uart_awready (uart_awready),
        .uart_wdata   (uart_wdata),
        .uart_wstrb   (uart_wstrb),
        .uart_wvalid  (uart_wvalid),
        .uart_wready  (uart_wready),
        .uart_bresp   (uart_bresp),
        .uart_bvalid  (uart_bvalid),
        .uart_bready  (uart_bready),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int n;
        logic [31:0] want;
        rd_q.push_back(exp);
        @(negedge clk);
        uart_araddr  = addr;
        uart_arvalid = 1'b1;
        n = 0;
        while (!uart_arready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check_val("ar_timeout", {31'b0, uart_arready}, 32'd1);
        check_val("rvalid_pre", {31'b0, uart_rvalid}, 32'd0);
        @(negedge clk);
        uart_arvalid = 1'b0;
        check_val("rvalid_lat", {31'b0, uart_rvalid}, 32'd1);
        n = 0;
        while (!uart_rvalid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        want = rd_q.pop_front();
        check_val($sformatf("rdata_%h", addr), uart_rdata, want);
        check_val("rresp", {30'b0, uart_rresp}, 32'd0);
        uart_rready = 1'b1;
        @(negedge clk);
        uart_rready = 1'b0;
        check_val("rvalid_drop", {31'b0, uart_rvalid}, 32'd0);
    endtask

    task automatic axi_aw(input logic [3:0] addr);
        int n;
        @(negedge clk);
        uart_awaddr  = addr;
        uart_awvalid = 1'b1;
        n = 0;
        while (!uart_awready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check_val("aw_timeout", {31'b0, uart_awready}, 32'd1);
        @(negedge clk);
        uart_awvalid = 1'b0;
    endtask

    task automatic axi_w(input logic [31:0] data);
        int n;
        @(negedge clk);
        uart_wdata  = data;
        uart_wstrb  = 4'h1;
        uart_wvalid = 1'b1;
        n = 0;
        while (!uart_wready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check_val("w_timeout", {31'b0, uart_wready}, 32'd1);
        @(negedge clk);
        uart_wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data);
        axi_aw(addr);
        axi_w(data);
        if (addr == 4'h4 && tx_q.size() < FIFO_DEPTH) tx_q.push_back(data[7:0]);
        check_val("bvalid", {31'b0, uart_bvalid}, 32'd1);
        check_val("bresp", {30'b0, uart_bresp}, 32'd0);
        uart_bready = 1'b1;
        @(negedge clk);
        uart_bready = 1'b0;
        check_val("bvalid_drop", {31'b0, uart_bvalid}, 32'd0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        int n;
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check_val("rx_timeout", {31'b0, rx_ready}, 32'd1);
        else rx_q.push_back(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_drain();
        int n;
        @(negedge clk);
        tx_ready = 1'b1;
        n = 0;
        while (tx_q.size() > 0 && n < BUDGET) begin
            check_val("tx_valid", {31'b0, tx_valid}, 32'd1);
            check_val("tx_byte", {24'b0, tx_byte}, {24'b0, tx_q.pop_front()});
            @(negedge clk);
            n++;
        end
        check_val("tx_valid_end", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        uart_araddr = '0; uart_arvalid = 1'b0; uart_rready = 1'b0;
        uart_awaddr = '0; uart_awvalid = 1'b0;
        uart_wdata = '0; uart_wstrb = '0; uart_wvalid = 1'b0; uart_bready = 1'b0;
        rx_byte = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        check_val("rst_arready", {31'b0, uart_arready}, 32'd1);
        check_val("rst_awready", {31'b0, uart_awready}, 32'd1);
        check_val("rst_wready",  {31'b0, uart_wready}, 32'd0);
        check_val("rst_rvalid",  {31'b0, uart_rvalid}, 32'd0);
        check_val("rst_bvalid",  {31'b0, uart_bvalid}, 32'd0);
        check_val("rst_rdata",   uart_rdata, 32'd0);
        check_val("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
        check_val("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_val("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
        rst = 1'b0;

        axi_read(4'h8, 32'h4);

        rx_push(8'h41);
        rx_push(8'h42);
        axi_read(4'h8, 32'h5);
        axi_read(4'h0, {24'b0, rx_q.pop_front()});
        axi_read(4'h0, {24'b0, rx_q.pop_front()});
        axi_read(4'h8, 32'h4);
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);
        axi_read(4'hC, 32'h0);

        // Split AW/W with bready held low; the next AW retires the response.
        axi_aw(4'h4);
        @(negedge clk);
        axi_w(32'h0000_005A);
        tx_q.push_back(8'h5A);
        check_val("gap_bvalid", {31'b0, uart_bvalid}, 32'd1);
        check_val("gap_tx_valid", {31'b0, tx_valid}, 32'd1);
        check_val("gap_tx_byte", {24'b0, tx_byte}, 32'h5A);
        repeat (3) @(negedge clk);
        check_val("bvalid_hold", {31'b0, uart_bvalid}, 32'd1);
        axi_aw(4'h4);
        check_val("aw_clears_bvalid", {31'b0, uart_bvalid}, 32'd0);
        axi_w(32'hFFFF_FFA5);
        tx_q.push_back(8'hA5);
        uart_bready = 1'b1;
        @(negedge clk);
        uart_bready = 1'b0;
        check_val("bready_clears", {31'b0, uart_bvalid}, 32'd0);
        tx_drain();

        for (int i = 0; i < FIFO_DEPTH; i++) axi_write(4'h4, 32'h10 + i);
        axi_read(4'h8, 32'h8);
        axi_write(4'h4, 32'hEE);
        axi_read(4'h8, 32'h8);
        axi_write(4'h0, 32'h77);
        axi_write(4'h8, 32'h77);
        tx_drain();

        for (int i = 0; i < FIFO_DEPTH; i++) rx_push(8'h60 + 8'(i));
        @(negedge clk);
        check_val("rx_full_ready", {31'b0, rx_ready}, 32'd0);
        rx_byte  = 8'h70;
        rx_valid = 1'b1;
        axi_read(4'h0, {24'b0, rx_q.pop_front()});
        rx_q.push_back(8'h70);
        rx_valid = 1'b0;
        check_val("rx_refull_ready", {31'b0, rx_ready}, 32'd0);
        axi_read(4'h8, 32'h7);
        while (rx_q.size() > 0) axi_read(4'h0, {24'b0, rx_q.pop_front()});
        axi_read(4'h8, 32'h4);

        rx_push(8'h11);
        rx_push(8'h22);
        axi_write(4'h4, 32'h33);
        axi_read(4'h8, 32'h1);
        axi_write(4'hC, 32'h3);
        rx_q.delete();
        tx_q.delete();
        axi_read(4'h8, 32'h4);
        check_val("clr_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_val("clr_rx_ready", {31'b0, rx_ready}, 32'd1);

        // Reset while a read response is outstanding drops it.
        @(negedge clk);
        uart_araddr  = 4'h8;
        uart_arvalid = 1'b1;
        @(negedge clk);
        uart_arvalid = 1'b0;
        check_val("rresp_pending", {31'b0, uart_rvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_rvalid", {31'b0, uart_rvalid}, 32'd0);
        check_val("rst_mid_arready", {31'b0, uart_arready}, 32'd1);
        rst = 1'b0;
        axi_read(4'h8, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
